// File: rtl/fetch_sequencer.sv
// fetch_sequencer: five-phase one-hot sequencer, program counter and
// instruction register for the 16-bit multi-cycle CPU.
// Optional feature: define FETCH_SEQUENCER_HALT_EN to make the HALT
// instruction (class 11, opcode 1111) freeze the sequencer in P5.
module fetch_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic [15:0] pc_load,
  input  logic        pc_load_en,
  input  logic        pc_hold,
  output logic [4:0]  phase,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        halted
);

  typedef enum logic [4:0] {
    P1 = 5'b00001,
    P2 = 5'b00010,
    P3 = 5'b00100,
    P4 = 5'b01000,
    P5 = 5'b10000
  } phase_t;

  phase_t      r_phase;
  phase_t      w_phase_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        w_stop;    // stay in P5 instead of wrapping to P1
  logic        w_frozen;  // block branch loads once halted

`ifdef FETCH_SEQUENCER_HALT_EN
  logic r_halted;
  logic w_is_halt;

  assign w_is_halt = (r_ir[15:14] == 2'b11) && (r_ir[7:4] == 4'b1111);
  assign w_stop    = w_is_halt;
  assign w_frozen  = r_halted;

  // Halt flag: set at the end of P5 of a HALT instruction, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset)
      r_halted <= 1'b0;
    else if (r_phase == P5 && w_is_halt)
      r_halted <= 1'b1;
  end

  assign halted = r_halted;
`else
  assign w_stop   = 1'b0;
  assign w_frozen = 1'b0;
  assign halted   = 1'b0;
`endif

  // Phase register
  always_ff @(posedge clock) begin
    if (reset)
      r_phase <= P1;
    else
      r_phase <= w_phase_next;
  end

  // Phase ring successor; P5 holds only when a HALT is being executed
  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      P1:      w_phase_next = P2;
      P2:      w_phase_next = P3;
      P3:      w_phase_next = P4;
      P4:      w_phase_next = P5;
      P5:      w_phase_next = w_stop ? P5 : P1;
      default: w_phase_next = P1;
    endcase
  end

  // Program counter: increment at the end of P1, branch load at the end of P5
  always_ff @(posedge clock) begin
    if (reset)
      r_pc <= 16'h0000;
    else if (r_phase == P1 && !pc_hold)
      r_pc <= r_pc + 16'd1;
    else if (r_phase == P5 && pc_load_en && !w_frozen)
      r_pc <= pc_load;
  end

  // Instruction register: capture the fetched word at the end of P1
  always_ff @(posedge clock) begin
    if (reset)
      r_ir <= 16'h0000;
    else if (r_phase == P1)
      r_ir <= mem_data;
  end

  assign phase = r_phase;
  assign pc    = r_pc;
  assign ir    = r_ir;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic compared against a behavioural model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mem_data;
  logic [15:0] pc_load;
  logic        pc_load_en;
  logic        pc_hold;
  logic [4:0]  phase;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        halted;

  always #5 clock = ~clock;

  fetch_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .mem_data   (mem_data),
    .pc_load    (pc_load),
    .pc_load_en (pc_load_en),
    .pc_hold    (pc_hold),
    .phase      (phase),
    .pc         (pc),
    .ir         (ir),
    .halted     (halted)
  );

  int errs   = 0;
  int checks = 0;

  // Behavioural model: phase index 0..4 (P1..P5), pc, ir, halted
  int          m_k  = 0;
  int unsigned m_pc = 0;
  int unsigned m_ir = 0;
  bit          m_h  = 0;
  bit          halt_en;

  typedef struct {
    logic        rst;
    logic [15:0] mem;
    logic [15:0] ld;
    logic        ld_en;
    logic        hold;
    logic [4:0]  e_phase;
    logic [15:0] e_pc;
    logic [15:0] e_ir;
  } vec_t;

  vec_t tbl [11];

  function automatic bit is_halt_word(input int unsigned w);
    return (((w >> 14) & 3) == 3) && (((w >> 4) & 15) == 15);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock of inputs, then advance the model by the same rules
  task automatic step(input bit r, input logic [15:0] md, input logic [15:0] ld,
                      input bit le, input bit h);
    reset      = r;
    mem_data   = md;
    pc_load    = ld;
    pc_load_en = le;
    pc_hold    = h;
    @(posedge clock);
    #1;
    if (r) begin
      m_k = 0; m_pc = 0; m_ir = 0; m_h = 0;
    end else if (m_k == 0) begin
      m_ir = md;
      if (!h) m_pc = (m_pc + 1) % 65536;
      m_k = 1;
    end else if (m_k < 4) begin
      m_k++;
    end else begin
      if (le && !m_h) m_pc = ld;
      if (halt_en && is_halt_word(m_ir)) begin
        m_h = 1;
        m_k = 4;
      end else begin
        m_k = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".phase"},  {11'b0, phase},  16'(1 << m_k));
    chk({tag, ".pc"},     pc,              16'(m_pc));
    chk({tag, ".ir"},     ir,              16'(m_ir));
    chk({tag, ".halted"}, {15'b0, halted}, 16'(m_h));
  endtask

  // Idle until the model reaches phase index k (bounded to one instruction)
  task automatic run_to(input int k);
    for (int i = 0; i < 5 && m_k != k; i++) begin
      step(0, 16'h0000, 16'h0000, 0, 0);
      check_model("idle");
    end
  endtask

  initial begin
`ifdef FETCH_SEQUENCER_HALT_EN
    halt_en = 1;
`else
    halt_en = 0;
`endif
    reset = 1'b1; mem_data = '0; pc_load = '0; pc_load_en = 1'b0; pc_hold = 1'b0;

    // Reset, then ten clocks fetching 16'hC150
    tbl[0]  = '{1'b1, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00001, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00010, 16'h0001, 16'hC150};
    tbl[2]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00100, 16'h0001, 16'hC150};
    tbl[3]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b01000, 16'h0001, 16'hC150};
    tbl[4]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b10000, 16'h0001, 16'hC150};
    tbl[5]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00001, 16'h0001, 16'hC150};
    tbl[6]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00010, 16'h0002, 16'hC150};
    tbl[7]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00100, 16'h0002, 16'hC150};
    tbl[8]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b01000, 16'h0002, 16'hC150};
    tbl[9]  = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b10000, 16'h0002, 16'hC150};
    tbl[10] = '{1'b0, 16'hC150, 16'h0, 1'b0, 1'b0, 5'b00001, 16'h0002, 16'hC150};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].mem, tbl[i].ld, tbl[i].ld_en, tbl[i].hold);
      chk($sformatf("tbl%0d.phase", i), {11'b0, phase}, {11'b0, tbl[i].e_phase});
      chk($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.ir", i), ir, tbl[i].e_ir);
      chk($sformatf("tbl%0d.halted", i), {15'b0, halted}, 16'h0000);
    end

    // PC wrap: load FFFF in P5, increment in the next P1
    run_to(4);
    step(0, 16'h0000, 16'hFFFF, 1, 0);
    chk("wrap.load", pc, 16'hFFFF);
    chk("wrap.p1", {11'b0, phase}, 16'h0001);
    step(0, 16'h0000, 16'h0000, 0, 0);
    chk("wrap.pc", pc, 16'h0000);
    check_model("wrap");

    // Branch: load enable held through a whole instruction
    run_to(0);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h1111, 16'h0040, 1, 0);
      check_model("branch");
    end
    chk("branch.target", pc, 16'h0040);
    step(0, 16'h2222, 16'h0040, 1, 0);
    chk("branch.fetch", pc, 16'h0041);
    chk("branch.ir", ir, 16'h2222);

    // pc_hold in P1 with pc = 5
    run_to(4);
    step(0, 16'h0000, 16'h0005, 1, 0);
    chk("hold.pre", pc, 16'h0005);
    step(0, 16'h1234, 16'h0000, 0, 1);
    chk("hold.pc", pc, 16'h0005);
    chk("hold.ir", ir, 16'h1234);

    // Reset asserted in P3
    step(0, 16'h0000, 16'h0000, 0, 0);
    chk("midrst.p3", {11'b0, phase}, 16'h0004);
    step(1, 16'hFFFF, 16'hFFFF, 1, 1);
    chk("midrst.phase", {11'b0, phase}, 16'h0001);
    chk("midrst.pc", pc, 16'h0000);
    chk("midrst.ir", ir, 16'h0000);

    // HALT word; load in its own P5 is taken, later loads are not
    step(0, 16'hC0F0, 16'h0000, 0, 0);
    check_model("halt.fetch");
    run_to(4);
    step(0, 16'h0000, 16'h0077, 1, 0);
    chk("halt.load", pc, 16'h0077);
    for (int i = 0; i < 12; i++) begin
      step(0, 16'h0000, 16'h0999, 1, 0);
      check_model("halt.run");
    end
`ifdef FETCH_SEQUENCER_HALT_EN
    chk("halt.phase", {11'b0, phase}, 16'h0010);
    chk("halt.flag", {15'b0, halted}, 16'h0001);
    chk("halt.pc", pc, 16'h0077);
`else
    chk("nohalt.flag", {15'b0, halted}, 16'h0000);
`endif
    step(1, 16'h0000, 16'h0000, 0, 0);
    chk("halt.rst.phase", {11'b0, phase}, 16'h0001);
    chk("halt.rst.flag", {15'b0, halted}, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      bit r;
      r = ($urandom_range(0, 63) == 0);
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        w[15:14] = 2'b11;
        w[7:4]   = 4'hF;
      end
      step(r, w, 16'($urandom), 1'($urandom), 1'($urandom));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
